// File: rtl/ds1302_access.sv
// Serial access engine for the DS1302 RTC: CE framing, SCLK generation, LSB-first shift.
// Define DS1302_ADDR_CHECK_EN to reject command bytes inconsistent with the requested direction.
module ds1302_access #(
  parameter int HALF_DIV = 25
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] Start_Sig,
  input  logic [7:0] Words_Addr,
  input  logic [7:0] Write_Data,
  output logic [7:0] Read_Data,
  output logic       Done_Sig,
  output logic       RTC_nRST,
  output logic       RTC_SCLK,
  inout  wire        RTC_DATA,
  output logic [3:0] dbg_status
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CE_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CE_HOLD  = 3'd3,
    DONE     = 3'd4,
    RELEASE  = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] frame;
  logic [7:0]  rx_shift;
  logic        is_read;
  logic        data_oe;
  logic        data_out;
  logic        start_req;
  logic        start_rd;
  logic        reject;
  logic        div_end;

  // Start_Sig handshake: 2'b10 / 2'b01 request an access; the engine then ignores
  // its inputs until it has passed DONE and seen Start_Sig return to 2'b00 or 2'b11.
  assign start_req = Start_Sig[1] ^ Start_Sig[0];
  assign start_rd  = (Start_Sig == 2'b01);
  assign div_end   = (div_cnt == DIV_LAST);

`ifdef DS1302_ADDR_CHECK_EN
  assign reject = !Words_Addr[7] || (Words_Addr[0] != start_rd);
`else
  assign reject = 1'b0;
`endif

  assign RTC_DATA   = data_oe ? data_out : 1'bz;
  assign dbg_status = {data_oe, state};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= 4'd0;
      frame     <= 16'd0;
      rx_shift  <= 8'd0;
      is_read   <= 1'b0;
      data_oe   <= 1'b0;
      data_out  <= 1'b0;
      Read_Data <= 8'h00;
      Done_Sig  <= 1'b0;
      RTC_nRST  <= 1'b0;
      RTC_SCLK  <= 1'b0;
    end else begin
      Done_Sig <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            is_read  <= start_rd;
            div_cnt  <= 8'd0;
            bit_cnt  <= 4'd0;
            rx_shift <= 8'd0;
            if (reject) begin
              Done_Sig <= 1'b1;
              state    <= DONE;
            end else begin
              frame    <= {Write_Data, Words_Addr};
              RTC_nRST <= 1'b1;
              RTC_SCLK <= 1'b0;
              data_oe  <= 1'b1;
              data_out <= Words_Addr[0];
              state    <= CE_SETUP;
            end
          end
        end
        CE_SETUP: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            if (!RTC_SCLK) begin
              RTC_SCLK <= 1'b1;
              // Read byte arrives on pulses 9..16; bit_cnt holds pulse number minus one.
              if (is_read && bit_cnt[3])
                rx_shift[bit_cnt[2:0]] <= RTC_DATA;
            end else begin
              RTC_SCLK <= 1'b0;
              if (bit_cnt == 4'd15) begin
                bit_cnt <= 4'd0;
                data_oe <= 1'b0;
                state   <= CE_HOLD;
              end else begin
                bit_cnt  <= bit_cnt + 4'd1;
                data_out <= frame[bit_cnt + 4'd1];
                if (is_read && bit_cnt == 4'd7)
                  data_oe <= 1'b0;
              end
            end
          end
        end
        CE_HOLD: begin
          if (div_end) begin
            div_cnt  <= 8'd0;
            RTC_nRST <= 1'b0;
            Done_Sig <= 1'b1;
            if (is_read)
              Read_Data <= rx_shift;
            state <= DONE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= RELEASE;
        end
        RELEASE: begin
          if (!start_req)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
